// File: rtl/audio_sample_scheduler_pkg.sv
// audio_sample_scheduler_pkg: shared widths, thresholds and FSM state encoding for the sample scheduler
package audio_sample_scheduler_pkg;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADC_W = 24;
   localparam int DEF_OUT_W = 12;
   localparam int DEF_DIV_W = 16;
   localparam int DEF_CNT_W = 10;
   localparam int MIN_FIFO_WORDS = 2;
   localparam int MIN_DIV_FIFO = 4;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RD_L,
      ST_RD_R,
      ST_CAP_R
   } state_e;
endpackage

// File: rtl/audio_sample_scheduler_rate_tick.sv
// rate_tick_gen: sample-period counter, one-cycle tick at cnt==div, new div picked up only at wrap
module rate_tick_gen #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);
   logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d;
   assign tick = !clear && cnt_q == div_q;
   always_comb begin
      cnt_d = clear || tick ? '0 : cnt_q + 1'b1;
      div_d = clear || tick ? div : div_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         div_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         div_q <= div_d;
      end
   end
endmodule

// File: rtl/audio_sample_scheduler.sv
// audio_sample_scheduler: per-period FIFO stereo mid-mix or ADC capture, presented as one OUT_W sample with a valid strobe
module audio_sample_scheduler
   import audio_sample_scheduler_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADC_W = DEF_ADC_W,
   parameter int OUT_W = DEF_OUT_W,
   parameter int DIV_W = DEF_DIV_W,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              src_sel,
   input  logic [DIV_W-1:0]  div,
   input  logic [DATA_W-1:0] fifo_dout,
   input  logic [CNT_W-1:0]  fifo_count,
   output logic              fifo_rd_en,
   input  logic [ADC_W-1:0]  adc_data,
   output logic [OUT_W-1:0]  sample,
   output logic              sample_valid,
   input  logic              status_clr,
   output logic              underrun,
   output logic              overrun
);
   state_e            state_q, state_d;
   logic [DATA_W-1:0] left_q, left_d, right_q, right_d;
   logic [OUT_W-1:0]  sample_q, sample_d;
   logic              valid_q, valid_d, rd_q, rd_d, under_q, under_d, over_q, over_d;
   logic              tick;
   logic [DATA_W:0]   pair_sum, hold_sum;
   logic              unused_bits;

   rate_tick_gen #(.DIV_W(DIV_W)) u_tick (
      .clk  (clk),
      .reset(reset),
      .clear(state_q == ST_IDLE),
      .div  (div),
      .tick (tick)
   );

   // One extra bit keeps the signed sum exact; its top OUT_W bits equal the halved mix's MSBs
   assign pair_sum = {left_q[DATA_W-1], left_q} + {fifo_dout[DATA_W-1], fifo_dout};
   assign hold_sum = {left_q[DATA_W-1], left_q} + {right_q[DATA_W-1], right_q};
   assign unused_bits = ^{pair_sum[DATA_W-OUT_W:0], hold_sum[DATA_W-OUT_W:0], adc_data[ADC_W-OUT_W-1:0]};

   always_comb begin
      state_d = state_q;
      left_d = left_q;
      right_d = right_q;
      sample_d = sample_q;
      valid_d = 1'b0;
      under_d = under_q & ~status_clr;
      over_d = over_q & ~status_clr;
      case (state_q)
         ST_IDLE: state_d = enable ? ST_WAIT : ST_IDLE;
         ST_WAIT: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (tick) begin
               if (!src_sel) begin
                  sample_d = adc_data[ADC_W-1 -: OUT_W];
                  valid_d = 1'b1;
               end else if (fifo_count >= CNT_W'(MIN_FIFO_WORDS)) begin
                  state_d = ST_RD_L;
               end else begin
                  sample_d = hold_sum[DATA_W -: OUT_W];
                  valid_d = 1'b1;
                  under_d = 1'b1;
               end
            end
         end
         ST_RD_L: state_d = ST_RD_R;
         ST_RD_R: begin
            left_d = fifo_dout;
            state_d = ST_CAP_R;
         end
         ST_CAP_R: begin
            right_d = fifo_dout;
            sample_d = pair_sum[DATA_W -: OUT_W];
            valid_d = 1'b1;
            state_d = enable ? ST_WAIT : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // A tick during a pair read is dropped; the pair itself is never disturbed
      if (tick && state_q inside {ST_RD_L, ST_RD_R, ST_CAP_R}) over_d = 1'b1;
      rd_d = state_d == ST_RD_L || state_d == ST_RD_R;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         left_q <= '0;
         right_q <= '0;
         sample_q <= '0;
         valid_q <= 1'b0;
         rd_q <= 1'b0;
         under_q <= 1'b0;
         over_q <= 1'b0;
      end else begin
         state_q <= state_d;
         left_q <= left_d;
         right_q <= right_d;
         sample_q <= sample_d;
         valid_q <= valid_d;
         rd_q <= rd_d;
         under_q <= under_d;
         over_q <= over_d;
      end
   end

   assign fifo_rd_en = rd_q;
   assign sample = sample_q;
   assign sample_valid = valid_q;
   assign underrun = under_q;
   assign overrun = over_q;
endmodule

// File: tb/tb_audio_sample_scheduler.sv
// tb_audio_sample_scheduler: FIFO model plus scoreboard of expected samples for the audio sample scheduler
module tb_audio_sample_scheduler;
   import audio_sample_scheduler_pkg::*;
   logic        clk = 1'b0;
   logic        reset, enable, src_sel, status_clr;
   logic [15:0] div;
   logic [31:0] fifo_dout = '0;
   logic [9:0]  fifo_count = '0;
   logic        fifo_rd_en;
   logic [23:0] adc_data;
   logic [11:0] sample;
   logic        sample_valid, underrun, overrun;
   int          errors = 0, checks = 0;
   int          cyc = 0, nvalid = 0, nrd = 0, last_rd = 0;
   int          vcyc[$];
   logic [11:0] exp_q[$];
   logic [31:0] fq[$];

   always #5 clk = ~clk;

   audio_sample_scheduler dut (
      .clk(clk), .reset(reset), .enable(enable), .src_sel(src_sel), .div(div),
      .fifo_dout(fifo_dout), .fifo_count(fifo_count), .fifo_rd_en(fifo_rd_en),
      .adc_data(adc_data), .sample(sample), .sample_valid(sample_valid),
      .status_clr(status_clr), .underrun(underrun), .overrun(overrun)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   function automatic logic [11:0] mix(input logic [31:0] l, input logic [31:0] r);
      longint s;
      s = (longint'($signed(l)) + longint'($signed(r))) >>> 1;
      return s[31:20];
   endfunction

   // Standard-mode FIFO: data appears the cycle after rd_en; reset flushes it
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset) fq.delete();
      else if (fifo_rd_en && fq.size() > 0) fifo_dout <= fq.pop_front();
      fifo_count <= 10'(fq.size());
   end

   always @(negedge clk) begin
      if (fifo_rd_en) begin
         nrd++;
         last_rd = cyc;
      end
      if (sample_valid) begin
         nvalid++;
         vcyc.push_back(cyc);
         chk("sb_nonempty", 32'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) chk("sample", {20'b0, sample}, {20'b0, exp_q.pop_front()});
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic wait_valid(input int target, input int budget, input string tag);
      int n = 0;
      while (nvalid < target && n < budget) begin
         step(1);
         n++;
      end
      chk({tag, "_timeout"}, 32'(nvalid >= target), 1);
   endtask

   task automatic wait_rd(input int budget);
      int n = 0;
      while (!fifo_rd_en && n < budget) begin
         step(1);
         n++;
      end
      chk("rd_timeout", {31'b0, fifo_rd_en}, 1);
   endtask

   task automatic push_pair(input logic [31:0] l, input logic [31:0] r);
      fq.push_back(l);
      fq.push_back(r);
      exp_q.push_back(mix(l, r));
   endtask

   initial begin
      int base, nr;
      logic [31:0] l, r;
      reset = 1'b1; enable = 1'b0; src_sel = 1'b0; status_clr = 1'b0; div = 16'd9; adc_data = '0;
      step(3);
      chk("rst_sample", {20'b0, sample}, 0);
      chk("rst_valid", {31'b0, sample_valid}, 0);
      chk("rst_rd", {31'b0, fifo_rd_en}, 0);
      chk("rst_under", {31'b0, underrun}, 0);
      chk("rst_over", {31'b0, overrun}, 0);
      reset = 1'b0;
      step(1);

      adc_data = 24'h7FF000;
      repeat (3) exp_q.push_back(12'h7FF);
      base = nvalid; nr = nrd;
      enable = 1'b1;
      wait_valid(base + 3, 60, "adc");
      enable = 1'b0;
      chk("adc_period", vcyc[$] - vcyc[$-1], 10);
      step(25);
      chk("adc_stop", nvalid, base + 3);
      chk("adc_rd", nrd - nr, 0);

      src_sel = 1'b1;
      fq.push_back(32'h4000_0000); fq.push_back(32'h2000_0000);
      exp_q.push_back(12'h300);
      base = nvalid; nr = nrd;
      enable = 1'b1;
      wait_valid(base + 1, 40, "fifo");
      enable = 1'b0;
      chk("fifo_rd", nrd - nr, 2);
      chk("fifo_lat", vcyc[$] - last_rd, 2);
      step(5);

      fq.push_back(32'h8000_0000); fq.push_back(32'h8000_0000);
      exp_q.push_back(12'h800);
      base = nvalid; nr = nrd;
      enable = 1'b1;
      wait_valid(base + 1, 40, "neg");
      enable = 1'b0;
      chk("neg_rd", nrd - nr, 2);
      chk("neg_under", {31'b0, underrun}, 0);
      chk("neg_over", {31'b0, overrun}, 0);
      step(5);

      fq.push_back(32'h7FFF_FFFF);
      exp_q.push_back(12'h800);
      base = nvalid; nr = nrd;
      enable = 1'b1;
      wait_valid(base + 1, 40, "under");
      enable = 1'b0;
      chk("under_rd", nrd - nr, 0);
      chk("under_set", {31'b0, underrun}, 1);
      step(3);
      chk("under_sticky", {31'b0, underrun}, 1);
      status_clr = 1'b1;
      step(1);
      status_clr = 1'b0;
      chk("under_clr", {31'b0, underrun}, 0);
      fq.delete();
      step(3);

      div = 16'd2;
      repeat (3) begin
         l = $urandom; r = $urandom;
         push_pair(l, r);
      end
      base = nvalid; nr = nrd;
      enable = 1'b1;
      wait_valid(base + 3, 120, "over");
      enable = 1'b0;
      chk("over_rd", nrd - nr, 6);
      chk("over_set", {31'b0, overrun}, 1);
      chk("over_under", {31'b0, underrun}, 0);
      step(5);

      div = 16'd9;
      l = $urandom; r = $urandom;
      push_pair(l, r);
      base = nvalid; nr = nrd;
      enable = 1'b1;
      wait_rd(40);
      step(1);
      enable = 1'b0;
      wait_valid(base + 1, 20, "drop");
      step(30);
      chk("drop_rd", nrd - nr, 2);
      chk("drop_idle", nvalid, base + 1);
      chk("drop_over", {31'b0, overrun}, 1);

      // This pair is abandoned by reset, so no sample is expected for it
      fq.push_back($urandom); fq.push_back($urandom);
      nr = nrd;
      enable = 1'b1;
      wait_rd(40);
      reset = 1'b1; enable = 1'b0;
      step(1);
      chk("rst2_rd", {31'b0, fifo_rd_en}, 0);
      chk("rst2_sample", {20'b0, sample}, 0);
      chk("rst2_valid", {31'b0, sample_valid}, 0);
      chk("rst2_over", {31'b0, overrun}, 0);
      reset = 1'b0;
      step(2);
      chk("rst2_reads", nrd - nr, 1);

      exp_q.push_back(12'h000);
      base = nvalid;
      enable = 1'b1;
      wait_valid(base + 1, 40, "hold0");
      enable = 1'b0;
      chk("hold0_under", {31'b0, underrun}, 1);
      step(3);

      src_sel = 1'b0; div = 16'd0; adc_data = 24'h123456;
      repeat (4) exp_q.push_back(12'h123);
      base = nvalid;
      enable = 1'b1;
      wait_valid(base + 4, 20, "div0");
      enable = 1'b0;
      chk("div0_period", vcyc[$] - vcyc[$-1], 1);
      step(5);
      chk("div0_stop", nvalid, base + 4);
      chk("sb_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
